// File: rtl/digit_setter.sv
// Multi-digit value entry driven by four active-low push keys.
// Each key gets a synchronizer, debounce filter and press detector (with
// optional auto-repeat); the top level edits the working value, moves the
// cursor and commits the value with a fixed-length update strobe.

module digit_setter_key #(
    parameter int DEB_CYCLES   = 4,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic event_o
);
    localparam int  DW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int  RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int  RW      = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam bit  REP_EN  = (REPEAT_DELAY > 0);
    localparam logic [DW-1:0] DEB_LOAD  = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LOAD  = RW'(REP_EN ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RATE_LOAD = RW'(REPEAT_RATE - 1);

    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          level_q, level_d;
    logic          prev_q, prev_d;
    logic [1:0]    vld_q, vld_d;
    logic          armed_q, armed_d;
    logic          rep_act_q, rep_act_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          event_q, event_d;
    logic          press;
    logic          rep_tc;

    // Debounce, arming, press detection and repeat timing.
    // A key only becomes armed once it has been seen released after reset,
    // so a key held through reset release never produces an event.
    always_comb begin
        sync_d    = {sync_q[0], key_n_i};
        vld_d     = {vld_q[0], 1'b1};
        prev_d    = level_q;
        level_d   = level_q;
        deb_cnt_d = DEB_LOAD;
        if (sync_q[1] != level_q) begin
            if (deb_cnt_q == '0) begin
                level_d = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q - DW'(1);
            end
        end

        armed_d = armed_q | (vld_q[1] & level_q & sync_q[1]);
        press   = armed_q & prev_q & ~level_q;
        rep_tc  = REP_EN & rep_act_q & ~level_q & (rep_cnt_q == '0);

        rep_act_d = rep_act_q & ~level_q;
        rep_cnt_d = rep_cnt_q;
        if (press) begin
            rep_act_d = REP_EN;
            rep_cnt_d = DLY_LOAD;
        end else if (rep_act_q) begin
            if (rep_cnt_q == '0) begin
                rep_cnt_d = RATE_LOAD;
            end else begin
                rep_cnt_d = rep_cnt_q - RW'(1);
            end
        end

        event_d = press | rep_tc;
    end

    // Front-end state register; released level after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            deb_cnt_q <= DEB_LOAD;
            level_q   <= 1'b1;
            prev_q    <= 1'b1;
            vld_q     <= 2'b00;
            armed_q   <= 1'b0;
            rep_act_q <= 1'b0;
            rep_cnt_q <= '0;
            event_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            prev_q    <= prev_d;
            vld_q     <= vld_d;
            armed_q   <= armed_d;
            rep_act_q <= rep_act_d;
            rep_cnt_q <= rep_cnt_d;
            event_q   <= event_d;
        end
    end

    assign event_o = event_q;
endmodule

module digit_setter #(
    parameter int DIGITS       = 2,
    parameter int DIGIT_W      = 4,
    parameter int DIGIT_MAX    = 15,
    parameter int CARRY        = 0,
    parameter int DEB_CYCLES   = 4,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 1,
    parameter int UPDATE_LEN   = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          key_up,
    input  logic                                          key_down,
    input  logic                                          key_next,
    input  logic                                          key_commit,
    output logic [DIGITS*DIGIT_W-1:0]                     edit,
    output logic [DIGITS*DIGIT_W-1:0]                     data,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] cursor,
    output logic                                          update
);
    localparam int W  = DIGITS * DIGIT_W;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int UW = (UPDATE_LEN > 1) ? $clog2(UPDATE_LEN) : 1;
    localparam bit RIPPLE = (CARRY != 0);
    localparam logic [DIGIT_W-1:0] DMAX     = DIGIT_W'(DIGIT_MAX);
    localparam logic [CW-1:0]      CUR_LAST = CW'(DIGITS - 1);
    localparam logic [UW-1:0]      UPD_LAST = UW'(UPDATE_LEN - 1);

    logic          ev_up, ev_dn, ev_nx, ev_cm;
    logic          do_up, do_dn;
    logic [W-1:0]  edit_q, edit_d;
    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic          upd_q, upd_d;
    logic [UW-1:0] upd_cnt_q, upd_cnt_d;
    logic [DIGIT_W-1:0] dig;
    logic          cry;

    digit_setter_key #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_RATE(REPEAT_RATE))
        u_key_up (.clk(clk), .reset(reset), .key_n_i(key_up), .event_o(ev_up));

    digit_setter_key #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                       .REPEAT_RATE(REPEAT_RATE))
        u_key_down (.clk(clk), .reset(reset), .key_n_i(key_down), .event_o(ev_dn));

    digit_setter_key #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(0), .REPEAT_RATE(1))
        u_key_next (.clk(clk), .reset(reset), .key_n_i(key_next), .event_o(ev_nx));

    digit_setter_key #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(0), .REPEAT_RATE(1))
        u_key_commit (.clk(clk), .reset(reset), .key_n_i(key_commit), .event_o(ev_cm));

    // Simultaneous up and down cancel each other.
    assign do_up = ev_up & ~ev_dn;
    assign do_dn = ev_dn & ~ev_up;

    // Digit edit: start at the cursor digit and ripple the wrap upwards when
    // carry is enabled; a wrap out of the top digit is dropped.
    always_comb begin
        edit_d = edit_q;
        cry    = 1'b0;
        dig    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = edit_q[k*DIGIT_W +: DIGIT_W];
            if (CW'(k) == cursor_q) begin
                cry = do_up | do_dn;
            end
            if (cry) begin
                if (do_up) begin
                    if (dig == DMAX) begin
                        dig = '0;
                    end else begin
                        dig = dig + DIGIT_W'(1);
                        cry = 1'b0;
                    end
                end else begin
                    if (dig == '0) begin
                        dig = DMAX;
                    end else begin
                        dig = dig - DIGIT_W'(1);
                        cry = 1'b0;
                    end
                end
                if (!RIPPLE) begin
                    cry = 1'b0;
                end
            end
            edit_d[k*DIGIT_W +: DIGIT_W] = dig;
        end
    end

    // Cursor advance, commit capture and update strobe timing.
    always_comb begin
        cursor_d  = cursor_q;
        data_d    = data_q;
        upd_d     = upd_q;
        upd_cnt_d = upd_cnt_q;
        if (ev_nx) begin
            cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + CW'(1);
        end
        if (ev_cm) begin
            data_d    = edit_q;
            upd_d     = 1'b1;
            upd_cnt_d = '0;
        end else if (upd_q) begin
            if (upd_cnt_q == UPD_LAST) begin
                upd_d = 1'b0;
            end else begin
                upd_cnt_d = upd_cnt_q + UW'(1);
            end
        end
    end

    // Value, cursor and strobe registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edit_q    <= '0;
            data_q    <= '0;
            cursor_q  <= '0;
            upd_q     <= 1'b0;
            upd_cnt_q <= '0;
        end else begin
            edit_q    <= edit_d;
            data_q    <= data_d;
            cursor_q  <= cursor_d;
            upd_q     <= upd_d;
            upd_cnt_q <= upd_cnt_d;
        end
    end

    assign edit   = edit_q;
    assign data   = data_q;
    assign cursor = cursor_q;
    assign update = upd_q;
endmodule
